// File: rtl/bpb_counter_table.sv
// Bimodal branch prediction buffer of 2-bit saturating counters with a reset sweep and a
// two-stage commit-time update pipeline. Define BPB_GSHARE_EN to XOR a global history into indices.
module bpb_counter_table #(
  parameter int unsigned           SIZE_PC         = 32,
  parameter int unsigned           FETCH_BANDWIDTH = 4,
  parameter int unsigned           BRANCH_TYPE     = 2,
  parameter logic [BRANCH_TYPE-1:0] COND_TYPE      = 2'b00,
  parameter int unsigned           SIZE_CNT_LOG    = 10,
  parameter logic [1:0]            CNT_INIT        = 2'b01
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetchEn_i,
  input  logic                       stall_i,
  input  logic [SIZE_PC-1:0]         pc_i,
  output logic [FETCH_BANDWIDTH-1:0] predDir_o,
  output logic                       predValid_o,
  output logic                       bpbReady_o,
  input  logic                       updateEn_i,
  input  logic                       updateDir_i,
  input  logic [SIZE_PC-1:0]         updatePC_i,
  input  logic [BRANCH_TYPE-1:0]     updateCtrlType_i
);

  localparam int unsigned NUM_ENTRIES = 1 << SIZE_CNT_LOG;

  typedef enum logic {StInit, StReady} bpbState_e;

  function automatic logic [SIZE_CNT_LOG-1:0] pcIdx(input logic [SIZE_PC-1:0] pc);
    return SIZE_CNT_LOG'(pc >> 3);
  endfunction

  function automatic logic [1:0] satCnt(input logic [1:0] cnt, input logic dir);
    if (dir) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else     return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  logic [1:0]              cntTable [NUM_ENTRIES];

  bpbState_e               stateQ, stateD;
  logic [SIZE_CNT_LOG-1:0] sweepQ, sweepD;
  logic                    ready;
  logic [SIZE_CNT_LOG-1:0] histIdx;

  // ---------------------------------------------------------------------------
  // Reset sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    sweepD = sweepQ;
    unique case (stateQ)
      StInit: begin
        sweepD = sweepQ + 1'b1;
        if (sweepQ == '1) stateD = StReady;
      end
      StReady: ;
      default: stateD = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StInit;
      sweepQ <= '0;
    end else begin
      stateQ <= stateD;
      sweepQ <= sweepD;
    end
  end

  assign ready      = (stateQ == StReady);
  assign bpbReady_o = ready;

  // ---------------------------------------------------------------------------
  // Update pipeline: U0 registers request and array value, U1 computes and writes
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic [SIZE_CNT_LOG-1:0] u0Idx;
  logic                    u1ValidQ, u1DirQ;
  logic [SIZE_CNT_LOG-1:0] u1IdxQ;
  logic [1:0]              u1CntQ, u1Base, u1NewCnt;
  logic                    wrValidQ;
  logic [SIZE_CNT_LOG-1:0] wrIdxQ;
  logic [1:0]              wrCntQ;

  assign accept = updateEn_i & ready & (updateCtrlType_i == COND_TYPE);
  assign u0Idx  = pcIdx(updatePC_i) ^ histIdx;

  always_ff @(posedge clk) begin
    if (reset) begin
      u1ValidQ <= 1'b0;
      wrValidQ <= 1'b0;
    end else begin
      u1ValidQ <= accept;
      wrValidQ <= u1ValidQ;
    end
  end

  // The U0 array read misses the write landing on the same edge, so forward it in U1.
  always_ff @(posedge clk) begin
    u1IdxQ <= u0Idx;
    u1DirQ <= updateDir_i;
    u1CntQ <= cntTable[u0Idx];
    wrIdxQ <= u1IdxQ;
    wrCntQ <= u1NewCnt;
  end

  always_comb begin
    u1Base   = (wrValidQ && (wrIdxQ == u1IdxQ)) ? wrCntQ : u1CntQ;
    u1NewCnt = satCnt(u1Base, u1DirQ);
  end

  always_ff @(posedge clk) begin
    if (stateQ == StInit) begin
      cntTable[sweepQ] <= CNT_INIT;
    end else if (u1ValidQ) begin
      cntTable[u1IdxQ] <= u1NewCnt;
    end
  end

`ifdef BPB_GSHARE_EN
  logic [SIZE_CNT_LOG-1:0] bhrQ;

  always_ff @(posedge clk) begin
    if (reset || (stateQ == StInit)) begin
      bhrQ <= '0;
    end else if (accept) begin
      bhrQ <= {bhrQ[SIZE_CNT_LOG-2:0], updateDir_i};
    end
  end

  assign histIdx = bhrQ;
`else
  assign histIdx = '0;
`endif

  // ---------------------------------------------------------------------------
  // Prediction path (reads see the array before any same-edge update write)
  // ---------------------------------------------------------------------------
  logic [SIZE_CNT_LOG-1:0]     predIdx [FETCH_BANDWIDTH];
  logic                        predRead;
  logic [FETCH_BANDWIDTH-1:0]  predDirQ;
  logic                        predValidQ;

  assign predRead = fetchEn_i & ~stall_i & ready;

  always_comb begin
    for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
      predIdx[k] = pcIdx(pc_i + (SIZE_PC'(k) << 3)) ^ histIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      predDirQ   <= '0;
      predValidQ <= 1'b0;
    end else if (!stall_i) begin
      predValidQ <= predRead;
      for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
        predDirQ[k] <= predRead & cntTable[predIdx[k]][1];
      end
    end
  end

  assign predDir_o   = predDirQ;
  assign predValid_o = predValidQ;

endmodule

// File: doc/bpb_counter_table.md
Name: bpb_counter_table

Overview:
- Bimodal branch prediction buffer (BPB) of 2-bit saturating counters.
- Sits in fetch stage 1 beside the BTB. Gives a per-slot direction prediction for the fetch block.
- Consumes the in-order commit-time update stream (updateEn/updateDir/updatePC/updateCtrlType) from the control-transfer queue.
- Uses a two-stage read-modify-write update pipeline with forwarding, and a reset-sweep FSM that initialises the table.

Parameters:
- SIZE_PC, 32, PC width.
- FETCH_BANDWIDTH, 4, prediction slots per fetch block.
- BRANCH_TYPE, 2, control-type width.
- COND_TYPE, 2'b00, control-type encoding for a conditional branch.
- SIZE_CNT_LOG, 10, log2 of table entries (1024).
- CNT_INIT, 2'b01, counter value written by the reset sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetchEn_i  in  1  fetch block valid this cycle
- stall_i  in  1  hold prediction outputs
- pc_i  in  SIZE_PC  fetch block PC; slot k PC = pc_i + 8*k
- predDir_o  out  FETCH_BANDWIDTH  registered taken prediction per slot
- predValid_o  out  1  predDir_o valid
- bpbReady_o  out  1  sweep complete, table usable
- updateEn_i  in  1  commit-time update valid
- updateDir_i  in  1  actual outcome (1 = taken)
- updatePC_i  in  SIZE_PC  PC of the updated branch
- updateCtrlType_i  in  BRANCH_TYPE  type of the updated branch

Behaviour:
- Index: idx(pc) = pc[SIZE_CNT_LOG+2:3] (8-byte instructions). Index arithmetic wraps modulo 2^SIZE_CNT_LOG.
- FSM states: INIT, READY.
  - reset -> INIT with sweep counter = 0.
  - INIT: write CNT_INIT to entry[sweep] each cycle and increment the counter. After entry 2^SIZE_CNT_LOG-1 is written -> READY.
  - Sweep takes exactly 2^SIZE_CNT_LOG cycles.
  - reset asserted in any state, including mid-sweep, restarts the sweep at 0.
- bpbReady_o: 0 in INIT, 1 in READY. Registered; rises the cycle after the last sweep write.
- Reset values: predDir_o = 0, predValid_o = 0, bpbReady_o = 0. Update pipeline valids = 0.
- Prediction path:
  - Cycle t with fetchEn_i & ~stall_i & READY: read the FETCH_BANDWIDTH entries idx(pc_i + 8k).
  - Cycle t+1: predDir_o[k] = counter[1]; predValid_o = 1.
  - stall_i = 1: predDir_o and predValid_o hold.
  - fetchEn_i = 0 without stall: predValid_o = 0, predDir_o = 0.
  - In INIT: predValid_o = 0, predDir_o = 0.
- Update pipeline:
  - U0 (cycle t): accept the request only if updateEn_i & READY & updateCtrlType_i == COND_TYPE. All other requests are dropped with no state change.
  - U1 (t+1): the registered request reads entry[idx]. New value = sat(cnt + 1) if dir, else sat(cnt - 1). Range 0..3; 3 + 1 -> 3, 0 - 1 -> 0.
  - Write happens at the end of U1. The result is visible to a prediction read in cycle t+2 (output at t+3).
- Forwarding: if the U1 index matches the entry written in the previous cycle, U1 uses the forwarded new value, not the array value. Back-to-back updates to the same index therefore accumulate exactly.
- Same-cycle prediction read and update write to the same index: the read returns the old value (read-before-write).
- The table accepts one update per cycle. No backpressure is needed, because the upstream queue releases at most one entry per cycle.
- Updates are never flushed; recovery does not affect this block.

Optional Feature:
- Macro BPB_GSHARE_EN.
- Defined:
  - Adds a SIZE_CNT_LOG-bit global history register, reset to 0.
  - On each accepted conditional update at U0: bhr <= {bhr[SIZE_CNT_LOG-2:0], updateDir_i}.
  - Both prediction and update indices become idx(pc) XOR bhr. The update uses the bhr value before its own shift.
  - The sweep also clears bhr.
- Undefined: pure bimodal indexing, no history register.

Test Plan:
- Release reset at cycle 0 -> bpbReady_o = 0 for 1024 cycles, 1 at cycle 1024. A fetch at pc_i = 0x100 then returns predDir_o = 4'b0000, predValid_o = 1.
- Taken update to PC 0x100 (type 00), then a fetch at 0x100 two cycles later -> counter 01->10; predDir_o[0] = 1 at the next cycle; slots 1-3 stay 0.
- Three consecutive-cycle updates to PC 0x208: taken, taken, not-taken -> final counter 10, verified by a fetch showing slot 0 = 1 (forwarding exercised).
- Five not-taken updates to PC 0x300 -> counter saturates at 00. A following single taken update gives 01; predDir_o slot 0 = 0.
- Update with updateCtrlType_i = 2'b01 at PC 0x100 -> table unchanged (slot 0 stays at its prior value).
- Assert reset at sweep cycle 500 for 1 cycle -> bpbReady_o stays 0 for 1024 cycles after release. Updates presented during INIT are dropped (table reads 01).
